// File: rtl/coin_collector_if.sv
// Bundle between the user panel / vending core side and the coin_collector front end.
// master drives the panel and core-state inputs; slave is the collector itself.
interface coin_collector_if;
    logic       coinValid;
    logic [1:0] coinType;
    logic       itemValid;
    logic [1:0] itemSel;
    logic       cancel;
    logic [1:0] serviceTypeIn;
    logic [1:0] reqNTD_50;
    logic [1:0] reqNTD_10;
    logic [1:0] reqNTD_5;
    logic [1:0] reqNTD_1;
    logic [1:0] reqItemType;
    logic       coinReject;
    logic       refundValid;
    logic [1:0] refundNTD_50;
    logic [1:0] refundNTD_10;
    logic [1:0] refundNTD_5;
    logic [1:0] refundNTD_1;
    logic [7:0] collectedValue;
    logic       busy;
    logic [7:0] txnCount;

    modport master (
        output coinValid, coinType, itemValid, itemSel, cancel, serviceTypeIn,
        input  reqNTD_50, reqNTD_10, reqNTD_5, reqNTD_1, reqItemType, coinReject,
        input  refundValid, refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1,
        input  collectedValue, busy, txnCount
    );

    modport slave (
        input  coinValid, coinType, itemValid, itemSel, cancel, serviceTypeIn,
        output reqNTD_50, reqNTD_10, reqNTD_5, reqNTD_1, reqItemType, coinReject,
        output refundValid, refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1,
        output collectedValue, busy, txnCount
    );
endinterface

// File: rtl/coin_collector.sv
// Coin collection front end for the vending core: accumulates coins, drives one request, tracks service.
// Optional idle auto-refund is enabled by defining COIN_IDLE_REFUND_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// COLLECT   | idle / accepting coins, no item chosen
// ARMED     | item latched, accepting coins, waiting for core ON
// DRIVE     | request presented to core, waiting for BUSY or timeout
// WAIT_DONE | core is serving, waiting for OFF to close the transaction
module coin_collector #(
    parameter int TIMEOUT_CYCLES = 63,
    parameter int IDLE_LIMIT     = 200
) (
    input  logic             clk,
    input  logic             reset,
    coin_collector_if.slave  bus
);
    typedef enum logic [1:0] {COLLECT, ARMED, DRIVE, WAIT_DONE} state_t;

    localparam logic [1:0] SVC_OFF  = 2'b00;
    localparam logic [1:0] SVC_ON   = 2'b01;
    localparam logic [1:0] SVC_BUSY = 2'b10;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("coin_collector: TIMEOUT_CYCLES out of range 1..255");
    end
    if (IDLE_LIMIT < 1 || IDLE_LIMIT > 255) begin : gBadIdle
        $error("coin_collector: IDLE_LIMIT out of range 1..255");
    end

    function automatic logic [7:0] coinValue(input logic [1:0] n50, input logic [1:0] n10,
                                             input logic [1:0] n5, input logic [1:0] n1);
        return 8'd50 * {6'd0, n50} + 8'd10 * {6'd0, n10} + 8'd5 * {6'd0, n5} + {6'd0, n1};
    endfunction

    state_t     state, nState;
    logic [1:0] cnt50, cnt10, cnt5, cnt1;
    logic [1:0] c50, c10, c5, c1;
    logic [1:0] h50, h10, h5, h1;
    logic [1:0] item, nItem;
    logic [7:0] timer, nTimer;
    logic [7:0] txn, nTxn;
    logic       nCoinRej, doRefund, clearHeld;
    logic [1:0] req50, req10, req5, req1, reqItem;
    logic [1:0] ref50, ref10, ref5, ref1;
    logic       coinRej, refValid;
    logic [7:0] value;
`ifdef COIN_IDLE_REFUND_EN
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_LIMIT - 1);
    logic [7:0] idleCnt, nIdle;
`endif

    always_comb begin
        nState    = state;
        nItem     = item;
        nTimer    = timer;
        nTxn      = txn;
        nCoinRej  = 1'b0;
        doRefund  = 1'b0;
        clearHeld = 1'b0;
        c50 = cnt50;
        c10 = cnt10;
        c5  = cnt5;
        c1  = cnt1;
`ifdef COIN_IDLE_REFUND_EN
        nIdle = 8'd0;
`endif
        // a coin that cannot be stored is handed back on the following cycle
        if (bus.coinValid) begin
            if (state == COLLECT || state == ARMED) begin
                case (bus.coinType)
                    2'b00:   if (cnt50 != 2'd3) c50 = cnt50 + 2'd1; else nCoinRej = 1'b1;
                    2'b01:   if (cnt10 != 2'd3) c10 = cnt10 + 2'd1; else nCoinRej = 1'b1;
                    2'b10:   if (cnt5  != 2'd3) c5  = cnt5  + 2'd1; else nCoinRej = 1'b1;
                    default: if (cnt1  != 2'd3) c1  = cnt1  + 2'd1; else nCoinRej = 1'b1;
                endcase
            end else begin
                nCoinRej = 1'b1;
            end
        end

        case (state)
            COLLECT: begin
                if (bus.cancel) begin
                    doRefund = |{c50, c10, c5, c1};
                end else if (bus.itemValid && bus.itemSel != 2'b00) begin
                    nItem  = bus.itemSel;
                    nState = ARMED;
                end
            end
            ARMED: begin
                if (bus.cancel) begin
                    doRefund = 1'b1;
                end else if (bus.itemValid && bus.itemSel == 2'b00) begin
                    nItem  = 2'b00;
                    nState = COLLECT;
                end else begin
                    if (bus.itemValid) nItem = bus.itemSel;
                    if (bus.serviceTypeIn == SVC_ON) begin
                        nState = DRIVE;
                        nTimer = 8'd0;
                    end
                end
            end
            DRIVE: begin
                if (bus.serviceTypeIn == SVC_BUSY) begin
                    clearHeld = 1'b1;
                    nItem     = 2'b00;
                    nState    = WAIT_DONE;
                end else if (timer == TIMEOUT_LAST) begin
                    doRefund = 1'b1;
                end else begin
                    nTimer = timer + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (bus.serviceTypeIn == SVC_OFF) begin
                    nTxn   = txn + 8'd1;
                    nState = COLLECT;
                end
            end
            default: nState = COLLECT;
        endcase

`ifdef COIN_IDLE_REFUND_EN
        if ((state == COLLECT || state == ARMED) && (|{cnt50, cnt10, cnt5, cnt1}) &&
            !bus.coinValid && !bus.itemValid && !bus.cancel) begin
            if (idleCnt == IDLE_LAST) doRefund = 1'b1;
            else                      nIdle    = idleCnt + 8'd1;
        end
`endif

        if (doRefund) begin
            nState = COLLECT;
            nItem  = 2'b00;
        end

        h50 = (doRefund || clearHeld) ? 2'd0 : c50;
        h10 = (doRefund || clearHeld) ? 2'd0 : c10;
        h5  = (doRefund || clearHeld) ? 2'd0 : c5;
        h1  = (doRefund || clearHeld) ? 2'd0 : c1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= COLLECT;
            cnt50    <= 2'd0;
            cnt10    <= 2'd0;
            cnt5     <= 2'd0;
            cnt1     <= 2'd0;
            item     <= 2'b00;
            timer    <= 8'd0;
            txn      <= 8'd0;
            req50    <= 2'd0;
            req10    <= 2'd0;
            req5     <= 2'd0;
            req1     <= 2'd0;
            reqItem  <= 2'b00;
            ref50    <= 2'd0;
            ref10    <= 2'd0;
            ref5     <= 2'd0;
            ref1     <= 2'd0;
            refValid <= 1'b0;
            coinRej  <= 1'b0;
            value    <= 8'd0;
`ifdef COIN_IDLE_REFUND_EN
            idleCnt  <= 8'd0;
`endif
        end else begin
            state    <= nState;
            cnt50    <= h50;
            cnt10    <= h10;
            cnt5     <= h5;
            cnt1     <= h1;
            item     <= nItem;
            timer    <= nTimer;
            txn      <= nTxn;
            req50    <= (nState == DRIVE) ? h50 : 2'd0;
            req10    <= (nState == DRIVE) ? h10 : 2'd0;
            req5     <= (nState == DRIVE) ? h5  : 2'd0;
            req1     <= (nState == DRIVE) ? h1  : 2'd0;
            reqItem  <= (nState == DRIVE) ? nItem : 2'b00;
            ref50    <= doRefund ? c50 : 2'd0;
            ref10    <= doRefund ? c10 : 2'd0;
            ref5     <= doRefund ? c5  : 2'd0;
            ref1     <= doRefund ? c1  : 2'd0;
            refValid <= doRefund;
            coinRej  <= nCoinRej;
            value    <= coinValue(h50, h10, h5, h1);
`ifdef COIN_IDLE_REFUND_EN
            idleCnt  <= nIdle;
`endif
        end
    end

    assign bus.reqNTD_50      = req50;
    assign bus.reqNTD_10      = req10;
    assign bus.reqNTD_5       = req5;
    assign bus.reqNTD_1       = req1;
    assign bus.reqItemType    = reqItem;
    assign bus.coinReject     = coinRej;
    assign bus.refundValid    = refValid;
    assign bus.refundNTD_50   = ref50;
    assign bus.refundNTD_10   = ref10;
    assign bus.refundNTD_5    = ref5;
    assign bus.refundNTD_1    = ref1;
    assign bus.collectedValue = value;
    assign bus.busy           = (state != COLLECT);
    assign bus.txnCount       = txn;
endmodule
